rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single write port of the pipeline register file between two write-back requesters: requester 0 is the in-order pipeline write-back and requester 1 is the long-latency unit return (multiply/divide, load miss). The block applies round-robin arbitration and registers the winning write onto the register file's writeEn/writeAddr/writeData port. It also keeps a per-register busy scoreboard, which the hazard unit uses to stall readers of registers with outstanding long-latency writes.

## Interface
- RF_WIDTH, 3, register address width; the register file has 2**RF_WIDTH entries.
- DATA_WIDTH, 16, register data width.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- wb0_valid  input  1  requester 0 has a write pending.
- wb0_addr  input  RF_WIDTH  requester 0 destination register.
- wb0_data  input  DATA_WIDTH  requester 0 write data.
- wb0_ready  output  1  requester 0 write is granted this cycle.
- wb1_valid, wb1_addr, wb1_data, wb1_ready  same as requester 0, for requester 1.
- rsv_en  input  1  issue stage reserves a destination for a long-latency op.
- rsv_addr  input  RF_WIDTH  register to mark busy.
- writeEn  output  1  registered write enable to the register file.
- writeAddr  output  RF_WIDTH  registered write address.
- writeData  output  DATA_WIDTH  registered write data.
- busy  output  2**RF_WIDTH  scoreboard; bit r = 1 means register r has an outstanding reserved write.

## Operation
- A handshake completes when valid && ready. ready is combinational from both valids and the round-robin pointer only; it never depends on ready from elsewhere.
- At most one grant per cycle. The output stage always accepts, so sustained throughput is one write per cycle.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - The pointer last_grant updates only on a grant.
  - No grant: the pointer holds.
- Grant with addr != 0: the next edge loads writeEn=1, writeAddr and writeData from the granted requester.
- Grant with addr == 0:
  - The request is consumed (ready=1) and the pointer updates.
  - writeEn loads 0; no register-file write occurs.
- No grant: writeEn loads 0. writeAddr and writeData hold their previous values.
- Requester inputs must stay stable while valid && !ready.
- Scoreboard, evaluated at each edge:
  - set: rsv_en && rsv_addr != 0 sets busy[rsv_addr].
  - clear: writeEn==1 clears busy[writeAddr] at the edge ending the cycle in which the write is presented.
  - Set and clear on the same register in the same edge: set wins (a new reservation overrides the retiring one).
  - Set and clear on different registers both take effect.
  - busy[0] is constant 0.
  - A reservation on an already-busy register leaves it busy; there is no counting.
- Reset (reset=0, asynchronous):
  - writeEn=0, writeAddr=0, writeData=0, busy=all 0.
  - last_grant=1, so requester 0 wins the first tie.
  - wb0_ready and wb1_ready are 0 while reset is asserted.
- Reset asserted mid-operation: any registered but unwritten write is dropped (writeEn forced 0) and all busy bits clear. Requesters must reissue.

## Timing
- Grant in cycle N → writeEn/writeAddr/writeData valid in cycle N+1 → register file updated at the rising edge ending cycle N+1.
- busy bit set by rsv_en in cycle N is visible in cycle N+1.
- busy bit cleared by a write presented in cycle N+1 reads 0 in cycle N+2, the same cycle the new register value is readable.
- Back-to-back grants: writeEn can be high every cycle.
- Alternating requesters under continuous contention: wb0, wb1, wb0, wb1 ...
- Reset deassertion is synchronised externally. The first grant can occur in the first cycle with reset=1.

## Test plan
- Reset: hold reset=0 with both valids high → both readies 0, writeEn=0, busy=0. Release reset → cycle 1 grants wb0.
- Single requester: wb1_valid, addr=5, data=16'hBEEF in cycle N → wb1_ready=1 in N; writeEn=1, writeAddr=5, writeData=16'hBEEF in N+1; writeEn=0 in N+2.
- Contention: both valid for 4 cycles, distinct addrs 1/2 → grants wb0, wb1, wb0, wb1; writeEn high 4 consecutive cycles.
- Register zero: wb0 addr=0 data=16'h1234 → wb0_ready=1; writeEn stays 0. rsv_en with addr 0 → busy stays 0.
- Scoreboard: rsv_en addr=3 in N → busy[3]=1 in N+1. wb1 write to 3 granted in N+2 → busy[3]=0 in N+4. Repeat with rsv_en addr=3 in N+3 (same edge as the clear) → busy[3] stays 1.
- Mid-operation reset: grant wb0 addr=4 in N, pulse reset=0 during N+1 → writeEn=0 immediately, busy all 0, and the next tie goes to wb0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file write port between the in-order
// write-back (requester 0) and the long-latency return path (requester 1).
// Round-robin arbitration, a registered write port, and a per-register busy
// scoreboard that the hazard unit uses to stall readers.
module rf_write_arbiter #(
    parameter int RF_WIDTH   = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb0_valid,
    input  logic [RF_WIDTH-1:0]       wb0_addr,
    input  logic [DATA_WIDTH-1:0]     wb0_data,
    output logic                      wb0_ready,
    input  logic                      wb1_valid,
    input  logic [RF_WIDTH-1:0]       wb1_addr,
    input  logic [DATA_WIDTH-1:0]     wb1_data,
    output logic                      wb1_ready,
    input  logic                      rsv_en,
    input  logic [RF_WIDTH-1:0]       rsv_addr,
    output logic                      writeEn,
    output logic [RF_WIDTH-1:0]       writeAddr,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic [(1<<RF_WIDTH)-1:0]  busy
);

    localparam int NUM_REGS = 1 << RF_WIDTH;

    // last_grant_q: 0 = requester 0 was granted most recently, 1 = requester 1.
    logic                  last_grant_q, last_grant_d;
    logic                  write_en_q, write_en_d;
    logic [RF_WIDTH-1:0]   write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic                  grant0, grant1;
    logic [RF_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Round-robin grant; on a tie the requester not granted last wins.
    // Readies are held low while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset) begin
            if (wb0_valid && wb1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = wb0_valid;
                grant1 = wb1_valid;
            end
        end
        wb0_ready = grant0;
        wb1_ready = grant1;
    end

    // Select the winning request and compute the next pointer and write port.
    // A write to register zero is consumed but never reaches the register file.
    always_comb begin
        win_addr     = grant1 ? wb1_addr : wb0_addr;
        win_data     = grant1 ? wb1_data : wb0_data;
        last_grant_d = last_grant_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (grant0 || grant1) begin
            last_grant_d = grant1;
            if (win_addr != '0) begin
                write_en_d   = 1'b1;
                write_addr_d = win_addr;
                write_data_d = win_data;
            end
        end
    end

    // Scoreboard: a retiring write clears its bit, a new reservation sets its
    // bit and takes priority on the same register; register zero never busy.
    always_comb begin
        busy_d = busy_q;
        if (write_en_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any pending write and clears the scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign writeEn   = write_en_q;
    assign writeAddr = write_addr_q;
    assign writeData = write_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed vector table plus hand-written
// sequences for reset entry/exit and mid-operation reset.
module tb_rf_write_arbiter;

    localparam int RW = 3;
    localparam int DW = 16;
    localparam int NV = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb0_valid, wb1_valid, rsv_en;
    logic [RW-1:0] wb0_addr, wb1_addr, rsv_addr;
    logic [DW-1:0] wb0_data, wb1_data;
    logic          wb0_ready, wb1_ready, writeEn;
    logic [RW-1:0] writeAddr;
    logic [DW-1:0] writeData;
    logic [7:0]    busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          v0;
        logic [RW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [RW-1:0] a1;
        logic [DW-1:0] d1;
        logic          rsv;
        logic [RW-1:0] ra;
        logic          er0;
        logic          er1;
        logic          ewe;
        logic [RW-1:0] ewa;
        logic [DW-1:0] ewd;
        logic [7:0]    ebusy;
    } vec_t;

    vec_t vecs [NV];

    rf_write_arbiter #(.RF_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData), .busy(busy)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v0, logic [RW-1:0] a0, logic [DW-1:0] d0,
                                logic v1, logic [RW-1:0] a1, logic [DW-1:0] d1,
                                logic rsv, logic [RW-1:0] ra,
                                logic er0, logic er1, logic ewe, logic [RW-1:0] ewa,
                                logic [DW-1:0] ewd, logic [7:0] ebusy);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.rsv = rsv; v.ra = ra; v.er0 = er0; v.er1 = er1; v.ewe = ewe;
        v.ewa = ewa; v.ewd = ewd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [RW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [RW-1:0] a1, input logic [DW-1:0] d1,
                         input logic rsv, input logic [RW-1:0] ra);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        rsv_en = rsv; rsv_addr = ra;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        drive(v.v0, v.a0, v.d0, v.v1, v.a1, v.d1, v.rsv, v.ra);
        reset = 1'b1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        @(negedge clk);
        chk($sformatf("v%0d wb0_ready", idx), 32'(wb0_ready), 32'(v.er0));
        chk($sformatf("v%0d wb1_ready", idx), 32'(wb1_ready), 32'(v.er1));
        chk($sformatf("v%0d writeEn", idx), 32'(writeEn), 32'(v.ewe));
        chk($sformatf("v%0d writeAddr", idx), 32'(writeAddr), 32'(v.ewa));
        chk($sformatf("v%0d writeData", idx), 32'(writeData), 32'(v.ewd));
        chk($sformatf("v%0d busy", idx), 32'(busy), 32'(v.ebusy));
    endtask

    initial begin
        //               v0 a0 d0        v1 a1 d1        rsv ra   r0 r1 we wa dw        busy
        vecs[0]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0,  1, 0, 0, 0, 16'h0000, 8'h00);
        vecs[1]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0,  0, 1, 1, 1, 16'h1111, 8'h00);
        vecs[2]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0,  1, 0, 1, 2, 16'h2222, 8'h00);
        vecs[3]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0,  0, 1, 1, 1, 16'h1111, 8'h00);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 2, 16'h2222, 8'h00);
        vecs[5]  = mk(0, 0, 16'h0000, 1, 5, 16'hBEEF, 0, 0,  0, 1, 0, 2, 16'h2222, 8'h00);
        vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 5, 16'hBEEF, 8'h00);
        vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 5, 16'hBEEF, 8'h00);
        vecs[8]  = mk(1, 0, 16'h1234, 0, 0, 16'h0000, 0, 0,  1, 0, 0, 5, 16'hBEEF, 8'h00);
        vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0,  0, 0, 0, 5, 16'hBEEF, 8'h00);
        vecs[10] = mk(1, 6, 16'h6666, 1, 7, 16'h7777, 0, 0,  0, 1, 0, 5, 16'hBEEF, 8'h00);
        vecs[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3,  0, 0, 1, 7, 16'h7777, 8'h00);
        vecs[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 7, 16'h7777, 8'h08);
        vecs[13] = mk(0, 0, 16'h0000, 1, 3, 16'h3333, 0, 0,  0, 1, 0, 7, 16'h7777, 8'h08);
        vecs[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 3, 16'h3333, 8'h08);
        vecs[15] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 3, 16'h3333, 8'h00);
        vecs[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3,  0, 0, 0, 3, 16'h3333, 8'h00);
        vecs[17] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 3, 16'h3333, 8'h08);
        vecs[18] = mk(0, 0, 16'h0000, 1, 3, 16'h4444, 0, 0,  0, 1, 0, 3, 16'h3333, 8'h08);
        vecs[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3,  0, 0, 1, 3, 16'h4444, 8'h08);
        vecs[20] = mk(1, 3, 16'h5555, 0, 0, 16'h0000, 0, 0,  1, 0, 0, 3, 16'h4444, 8'h08);
        vecs[21] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5,  0, 0, 1, 3, 16'h5555, 8'h08);
        vecs[22] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5,  0, 0, 0, 3, 16'h5555, 8'h20);
        vecs[23] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 3, 16'h5555, 8'h20);

        // Hold reset with both requesters asking: nothing may be granted.
        reset = 1'b0;
        drive(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst wb0_ready", 32'(wb0_ready), 32'd0);
        chk("rst wb1_ready", 32'(wb1_ready), 32'd0);
        chk("rst writeEn", 32'(writeEn), 32'd0);
        chk("rst writeAddr", 32'(writeAddr), 32'd0);
        chk("rst writeData", 32'(writeData), 32'(16'h0000));
        chk("rst busy", 32'(busy), 32'd0);

        // Reset is released together with the first vector.
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Mid-operation reset: pointer currently favours wb1, busy[5] is set.
        @(posedge clk);
        #1;
        drive(1, 4, 16'h4040, 0, 0, 16'h0000, 0, 0);
        @(negedge clk);
        chk("mid grant wb0_ready", 32'(wb0_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        chk("mid pre writeEn", 32'(writeEn), 32'd1);
        chk("mid pre writeAddr", 32'(writeAddr), 32'd4);
        reset = 1'b0;
        #1;
        chk("mid rst writeEn", 32'(writeEn), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        drive(1, 1, 16'hA0A0, 1, 2, 16'hB0B0, 0, 0);
        #1;
        chk("mid rst wb0_ready", 32'(wb0_ready), 32'd0);
        chk("mid rst wb1_ready", 32'(wb1_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post rst tie wb0_ready", 32'(wb0_ready), 32'd1);
        chk("post rst tie wb1_ready", 32'(wb1_ready), 32'd0);
        @(posedge clk);
        #1;
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        chk("post rst writeEn", 32'(writeEn), 32'd1);
        chk("post rst writeAddr", 32'(writeAddr), 32'd1);
        chk("post rst writeData", 32'(writeData), 32'(16'hA0A0));

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
